// File: rtl/stream_to_mem_mux_pkg.sv
// Shared helpers for stream_to_mem_mux: index/credit width functions and assertion messages.
package stream_to_mem_mux_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One extra bit keeps the compare against BufDepth free of wrap-around.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1) + 1;
    endfunction

    localparam string MsgEmptyId     = "stream_to_mem_mux: memory response with no outstanding request";
    localparam string MsgBufOverflow = "stream_to_mem_mux: response pushed into a full port buffer";

endpackage

// File: rtl/stream_to_mem_mux_stream_fifo.sv
// stream_fifo: valid/ready FIFO of type T; FALL_THROUGH=1 forwards the input combinationally when empty.
module stream_fifo
    import stream_to_mem_mux_pkg::*;
#(
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  DEPTH        = 2,
    parameter type T            = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  T     data_i,
    input  logic valid_i,
    output logic ready_o,
    output T     data_o,
    output logic valid_o,
    input  logic ready_i
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty, full, push, pop;

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == DepthC);
        ready_o = ~full;
        valid_o = ~empty | (FALL_THROUGH & valid_i);
        data_o  = empty ? data_i : mem_q[rd_ptr_q];
        // A fall-through beat consumed in the same cycle never touches storage.
        push    = valid_i & ~full & ~(FALL_THROUGH & empty & ready_i);
        pop     = ready_i & ~empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + AW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push && pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/stream_to_mem_mux.sv
// stream_to_mem_mux: round-robin mux of NumPorts request streams onto one memory port with in-order
// response routing. Define STREAM_TO_MEM_MUX_GRANT_LOCK_EN to hold the grant until the memory handshake.
module stream_to_mem_mux
    import stream_to_mem_mux_pkg::*;
#(
    parameter type mem_req_t      = logic,
    parameter type mem_resp_t     = logic,
    parameter int  NumPorts       = 2,
    parameter int  BufDepth       = 1,
    parameter int  MaxOutstanding = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  mem_req_t  [NumPorts-1:0] req_i,
    input  logic      [NumPorts-1:0] req_valid_i,
    output logic      [NumPorts-1:0] req_ready_o,
    output mem_resp_t [NumPorts-1:0] resp_o,
    output logic      [NumPorts-1:0] resp_valid_o,
    input  logic      [NumPorts-1:0] resp_ready_i,
    output mem_req_t                 mem_req_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    input  mem_resp_t                mem_resp_i,
    input  logic                     mem_resp_valid_i,
    output logic                     idle_o
);
    localparam int IdxW = idx_width(NumPorts);
    localparam int CntW = cnt_width(BufDepth);
    localparam logic [CntW-1:0] BufDepthC = CntW'(BufDepth);

    typedef logic [IdxW-1:0] idx_t;

    logic [NumPorts-1:0]           elig, resp_hs, buf_push, buf_ready;
    logic [NumPorts-1:0][CntW-1:0] cnt_q, cnt_d;
    idx_t                          gnt, rr_q, rr_d, id_head;
    logic                          found, mem_hs, id_ready, id_valid, id_full;
`ifdef STREAM_TO_MEM_MUX_GRANT_LOCK_EN
    idx_t                          lock_q, lock_d;
    logic                          lock_valid_q, lock_valid_d;
`endif

    assign id_full = ~id_ready;

    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
        assign resp_hs[gi]     = resp_valid_o[gi] & resp_ready_i[gi];
        // A response leaving this cycle frees the credit the new request needs.
        assign elig[gi]        = req_valid_i[gi] & ((cnt_q[gi] < BufDepthC) | resp_hs[gi]) & ~id_full;
        assign req_ready_o[gi] = (gnt == idx_t'(gi)) & elig[gi] & mem_req_ready_i;
        assign buf_push[gi]    = mem_resp_valid_i & id_valid & (id_head == idx_t'(gi));

        stream_fifo #(
            .FALL_THROUGH (1'b1),
            .DEPTH        (BufDepth),
            .T            (mem_resp_t)
        ) i_resp_buf (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .data_i  (mem_resp_i),
            .valid_i (buf_push[gi]),
            .ready_o (buf_ready[gi]),
            .data_o  (resp_o[gi]),
            .valid_o (resp_valid_o[gi]),
            .ready_i (resp_ready_i[gi])
        );
    end

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            if (!found && elig[(int'(rr_q) + i) % NumPorts]) begin
                found = 1'b1;
                gnt   = idx_t'((int'(rr_q) + i) % NumPorts);
            end
        end
`ifdef STREAM_TO_MEM_MUX_GRANT_LOCK_EN
        if (lock_valid_q) begin
            gnt   = lock_q;
            found = elig[lock_q];
        end
`endif
        mem_req_valid_o = found;
        mem_req_o       = req_i[gnt];
        mem_hs          = found & mem_req_ready_i;
        rr_d            = mem_hs ? idx_t'((int'(gnt) + 1) % NumPorts) : rr_q;

        for (int p = 0; p < NumPorts; p++) begin
            cnt_d[p] = cnt_q[p];
            if (req_ready_o[p] && !resp_hs[p])      cnt_d[p] = cnt_q[p] + CntW'(1);
            else if (!req_ready_o[p] && resp_hs[p]) cnt_d[p] = cnt_q[p] - CntW'(1);
        end
`ifdef STREAM_TO_MEM_MUX_GRANT_LOCK_EN
        lock_valid_d = found & ~mem_req_ready_i;
        lock_d       = gnt;
`endif
    end

    assign idle_o = (cnt_q == '0) & ~id_valid;

    stream_fifo #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (MaxOutstanding),
        .T            (idx_t)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (gnt),
        .valid_i (mem_hs),
        .ready_o (id_ready),
        .data_o  (id_head),
        .valid_o (id_valid),
        .ready_i (mem_resp_valid_i)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q         <= '0;
            cnt_q        <= '0;
`ifdef STREAM_TO_MEM_MUX_GRANT_LOCK_EN
            lock_q       <= '0;
            lock_valid_q <= 1'b0;
`endif
        end else begin
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
`ifdef STREAM_TO_MEM_MUX_GRANT_LOCK_EN
            lock_q       <= lock_d;
            lock_valid_q <= lock_valid_d;
`endif
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_resp_valid_i && !id_valid)) else $error("%s", MsgEmptyId);
            for (int p = 0; p < NumPorts; p++) begin
                assert (!(buf_push[p] && !buf_ready[p])) else $error("%s (port %0d)", MsgBufOverflow, p);
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_to_mem_mux.sv
// Directed bench for stream_to_mem_mux with a latency-configurable memory model and per-port scoreboard.
module tb_stream_to_mem_mux;
    localparam int NP     = 2;
    localparam int MAXOUT = 2;
    localparam logic [15:0] KEY = 16'h5A3C;
`ifdef STREAM_TO_MEM_MUX_GRANT_LOCK_EN
    localparam int HOLD_PORT = 0;
`else
    localparam int HOLD_PORT = 1;
`endif

    typedef logic [15:0] req_t;
    typedef logic [15:0] resp_t;
    typedef struct { int due; resp_t data; } mresp_t;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    req_t  [NP-1:0]    req_i;
    logic  [NP-1:0]    req_valid_i;
    logic  [NP-1:0]    req_ready_o;
    resp_t [NP-1:0]    resp_o;
    logic  [NP-1:0]    resp_valid_o;
    logic  [NP-1:0]    resp_ready_i;
    req_t              mem_req_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    resp_t             mem_resp_i;
    logic              mem_resp_valid_i;
    logic              idle_o;

    stream_to_mem_mux #(
        .mem_req_t      (req_t),
        .mem_resp_t     (resp_t),
        .NumPorts       (NP),
        .BufDepth       (1),
        .MaxOutstanding (MAXOUT)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .req_i            (req_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .resp_o           (resp_o),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .mem_req_o        (mem_req_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_resp_i       (mem_resp_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .idle_o           (idle_o)
    );

    always #5 clk_i = ~clk_i;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;
    int     lat   = 1;
    int     n_out = 0;
    int     seq   = 100;
    mresp_t mq[$];
    resp_t  exp_q [NP][$];
    int     gnt_log[$];
    int     acc_cnt [NP];
    int     resp_cnt [NP];
    bit     [NP-1:0] hs_seen = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: answers each accepted request with req ^ KEY after lat cycles.
    initial begin
        mem_resp_valid_i = 1'b0;
        mem_resp_i       = '0;
        forever begin
            @(posedge clk_i);
            cyc++;
            #1;
            if (!rst_ni) begin
                mq.delete();
                mem_resp_valid_i = 1'b0;
                mem_resp_i       = '0;
            end else if (mq.size() > 0 && mq[0].due == cyc) begin
                mem_resp_valid_i = 1'b1;
                mem_resp_i       = mq[0].data;
                void'(mq.pop_front());
            end else begin
                mem_resp_valid_i = 1'b0;
                mem_resp_i       = '0;
            end
        end
    end

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            for (int p = 0; p < NP; p++) exp_q[p].delete();
            n_out = 0;
        end else begin
            check("max_outstanding", 32'(n_out <= MAXOUT), 1);
            if (n_out >= MAXOUT) check("idfull_blocks_issue", 32'(mem_req_valid_o), 0);
            for (int p = 0; p < NP; p++) begin
                if (resp_valid_o[p] && resp_ready_i[p]) begin
                    resp_cnt[p]++;
                    check($sformatf("resp_pending_p%0d", p), 32'(exp_q[p].size() > 0), 1);
                    if (exp_q[p].size() > 0)
                        check($sformatf("resp_data_p%0d", p), 32'(resp_o[p]), 32'(exp_q[p].pop_front()));
                    $display("resp port%0d data=%04h", p, resp_o[p]);
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (req_valid_i[p] && req_ready_o[p]) begin
                    check($sformatf("grant_payload_p%0d", p), 32'(mem_req_o), 32'(req_i[p]));
                    exp_q[p].push_back(req_i[p] ^ KEY);
                    acc_cnt[p]++;
                    gnt_log.push_back(p);
                    hs_seen[p] = 1'b1;
                    $display("req  port%0d data=%04h", p, req_i[p]);
                end
            end
            if (mem_req_valid_o && mem_req_ready_i)
                mq.push_back('{due: cyc + lat, data: mem_req_o ^ KEY});
            n_out = n_out + int'(mem_req_valid_o && mem_req_ready_i) - int'(mem_resp_valid_i);
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs_seen[p]) begin
                hs_seen[p] = 1'b0;
                seq++;
                req_i[p] = {4'(p), 12'(seq)};
            end
        end
    endtask

    task automatic clear_counts();
        for (int p = 0; p < NP; p++) begin
            acc_cnt[p]  = 0;
            resp_cnt[p] = 0;
        end
        gnt_log.delete();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        resp_ready_i = '1;
        while (idle_o !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_idle"}, 32'(idle_o), 1);
        check({tag, "_sb_empty"}, 32'(exp_q[0].size() + exp_q[1].size()), 0);
    endtask

    task automatic check_gnt(input string tag, input int idx, input int exp);
        int g = (idx < gnt_log.size()) ? gnt_log[idx] : -1;
        check(tag, 32'(g), 32'(exp));
    endtask

    initial begin
        rst_ni          = 1'b1;
        req_i[0]        = 16'h0001;
        req_i[1]        = 16'h1001;
        req_valid_i     = '0;
        resp_ready_i    = '0;
        mem_req_ready_i = 1'b0;
        clear_counts();
        #2 rst_ni = 1'b0;
        #1;
        check("rst_idle", 32'(idle_o), 1);
        check("rst_resp_valid", 32'(resp_valid_o), 0);
        check("rst_mem_req_valid", 32'(mem_req_valid_o), 0);
        req_valid_i = 2'b10;
        #1;
        check("rst_comb_valid", 32'(mem_req_valid_o), 1);
        check("rst_comb_payload", 32'(mem_req_o), 32'(req_i[1]));
        req_valid_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_idle", 32'(idle_o), 1);
        check("post_rst_resp_valid", 32'(resp_valid_o), 0);
        check("post_rst_mem_req_valid", 32'(mem_req_valid_o), 0);

        // Both ports streaming, latency 1: grants alternate, one beat per cycle.
        step();
        lat = 1; resp_ready_i = 2'b11; mem_req_ready_i = 1'b1;
        clear_counts();
        req_valid_i = 2'b11;
        repeat (8) step();
        req_valid_i = '0;
        check("p1_grants", 32'(gnt_log.size()), 8);
        for (int i = 0; i < 8; i++) check_gnt($sformatf("p1_gnt%0d", i), i, i % 2);
        drain("p1");
        check("p1_resp0", 32'(resp_cnt[0]), 4);
        check("p1_resp1", 32'(resp_cnt[1]), 4);

        // Port 0 stalls its response: one credit used, port 1 keeps full rate.
        clear_counts();
        resp_ready_i = 2'b10;
        req_valid_i  = 2'b11;
        repeat (8) step();
        req_valid_i = '0;
        check("p2_acc0", 32'(acc_cnt[0]), 1);
        check("p2_acc1", 32'(acc_cnt[1]), 7);
        check("p2_p0_held", 32'(resp_valid_o[0]), 1);
        drain("p2");
        check("p2_resp0", 32'(resp_cnt[0]), 1);
        check("p2_resp1", 32'(resp_cnt[1]), 7);

        // Latency 3 against two outstanding slots: issue pairs separated by stalls.
        clear_counts();
        lat = 3;
        req_valid_i = 2'b11;
        repeat (12) step();
        req_valid_i = '0;
        check("p3_grants", 32'(gnt_log.size()), 6);
        for (int i = 0; i < 6; i++) check_gnt($sformatf("p3_gnt%0d", i), i, i % 2);
        drain("p3");

        // Move the round-robin pointer to port 1, then stall memory.
        lat = 1;
        req_valid_i = 2'b01;
        step();
        req_valid_i = '0;
        drain("p4pre");
        mem_req_ready_i = 1'b0;
        req_valid_i = 2'b01;
        @(negedge clk_i);
        check("p4_first_valid", 32'(mem_req_valid_o), 1);
        check("p4_first_payload", 32'(mem_req_o), 32'(req_i[0]));
        step();
        req_valid_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check($sformatf("p4_hold%0d", i), 32'(mem_req_o), 32'(req_i[HOLD_PORT]));
            step();
        end
        clear_counts();
        mem_req_ready_i = 1'b1;
        step();
        step();
        req_valid_i = '0;
        check("p4_grants", 32'(gnt_log.size()), 2);
        check_gnt("p4_gnt0", 0, HOLD_PORT);
        check_gnt("p4_gnt1", 1, 1 - HOLD_PORT);
        drain("p4");

        // Reset with two requests in flight.
        lat = 3;
        req_valid_i = 2'b11;
        step();
        step();
        req_valid_i = '0;
        check("p5_busy", 32'(idle_o), 0);
        rst_ni = 1'b0;
        #1;
        check("p5_rst_clear", 32'(idle_o), 1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;
        @(negedge clk_i);
        check("p5_post_idle", 32'(idle_o), 1);
        check("p5_post_resp_valid", 32'(resp_valid_o), 0);
        repeat (5) step();
        check("p5_quiet_idle", 32'(idle_o), 1);
        check("p5_quiet_resp", 32'(resp_valid_o), 0);
        lat = 1;
        req_valid_i = 2'b11;
        step();
        step();
        req_valid_i = '0;
        drain("p5_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
